// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared AHB-Lite types, response codes and byte-lane helper
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } slv_state_e;

  // Little-endian lane mask for a transfer of the given size at byte offset addr.
  function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] m;
    case (hsize)
      3'd0:    m = 4'b0001 << addr;
      3'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
      3'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus bundle with master and slave views
interface ahb_lite;
  logic        hselx;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hport;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hready_in;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hselx, haddr, hwrite, hsize, hburst, hport, htrans, hmastlock, hready_in, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hselx, haddr, hwrite, hsize, hburst, hport, htrans, hmastlock, hready_in, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave_sram_be_array.sv
// rtl/ahb_sram_slave_sram_be_array.sv - word array with byte-enable write and async read
module sram_be_array #(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [3:0]                   i_be,
  input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
  input  logic [31:0]                  i_wdata,
  output logic [31:0]                  o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM responder with programmable wait states and ERROR response
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input logic    hclk,
  input logic    hrstn,
  ahb_lite.slave bus
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  LAST_WAIT = 4'(WAIT_STATES - 1);

  slv_state_e    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_lane;
  logic          r_write;
  logic [2:0]    r_size;
  logic          r_legal;
  logic          r_hready;
  logic          r_hresp;

  logic [31:0] w_offset;
  logic        w_aligned;
  logic        w_legal;
  logic        w_open;
  logic        w_accept;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_offset = bus.haddr - BASE_ADDR;

  always_comb begin
    w_aligned = 1'b0;
    case (hsize_e'(bus.hsize))
      HSIZE_BYTE: w_aligned = 1'b1;
      HSIZE_HALF: w_aligned = ~bus.haddr[0];
      HSIZE_WORD: w_aligned = (bus.haddr[1:0] == 2'b00);
      default:    w_aligned = 1'b0;
    endcase
  end

  assign w_legal  = (w_offset < MEM_BYTES) && w_aligned;
  // Address phases are only sampled in states that are completing or have nothing pending.
  assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
  assign w_accept = w_open && bus.hselx && bus.hready_in &&
                    (htrans_e'(bus.htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign w_we     = (r_state == S_DONE) && r_write && r_legal;
  assign w_be     = byte_mask(r_size, r_lane);
  assign w_unused = ^{bus.hburst, bus.hport, bus.hmastlock};

  always_ff @(posedge hclk or posedge hrstn) begin
    if (hrstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_lane   <= 2'd0;
      r_write  <= 1'b0;
      r_size   <= 3'd0;
      r_legal  <= 1'b0;
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == LAST_WAIT) begin
            r_state  <= S_DONE;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        default: begin
          if (w_accept) begin
            r_addr  <= w_offset[AW+1:2];
            r_lane  <= bus.haddr[1:0];
            r_write <= bus.hwrite;
            r_size  <= bus.hsize;
            r_legal <= w_legal;
            if (!w_legal) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              r_state  <= S_WAIT;
              r_cnt    <= 4'd0;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_OKAY;
            end else begin
              r_state  <= S_DONE;
              r_hready <= 1'b1;
              r_hresp  <= HRESP_OKAY;
            end
          end else begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  sram_be_array #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk     (hclk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (r_addr),
    .i_wdata (bus.hwdata),
    .o_rdata (w_rdata)
  );

  // Write commits at the end of DONE, so a following read's DONE already sees it.
  assign bus.hrdata = (r_state == S_DONE) ? w_rdata : 32'd0;
  assign bus.hready = r_hready;
  assign bus.hresp  = r_hresp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized bench for ahb_sram_slave against a per-transfer reference model
module tb_ahb_sram_slave;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hrstn = 1'b1;
  logic        d_dut = 1'b0;
  logic        d_sel = 1'b0;
  logic [1:0]  d_trans = 2'b00;
  logic [31:0] d_addr = 32'd0;
  logic        d_write = 1'b0;
  logic [2:0]  d_size = 3'd0;
  logic [2:0]  d_burst = 3'd0;
  logic [3:0]  d_prot = 4'd0;
  logic        d_lock = 1'b0;
  logic [31:0] d_wdata = 32'd0;

  logic        obs_rdy;
  logic        obs_rsp;
  logic [31:0] obs_rd;

  int          n_vec = 0;
  int          n_err = 0;
  int          ws [2] = '{2, 0};
  logic [31:0] mdl [2][256];
  xfer_t       q[$];
  xfer_t       dp;
  bit          dp_act = 1'b0;
  int          dp_k = 0;

  always #5 hclk = ~hclk;

  ahb_lite bus0();
  ahb_lite bus1();

  assign bus0.hselx     = d_sel && (d_dut == 1'b0);
  assign bus1.hselx     = d_sel && (d_dut == 1'b1);
  assign bus0.haddr     = d_addr;
  assign bus1.haddr     = d_addr;
  assign bus0.hwrite    = d_write;
  assign bus1.hwrite    = d_write;
  assign bus0.hsize     = d_size;
  assign bus1.hsize     = d_size;
  assign bus0.hburst    = d_burst;
  assign bus1.hburst    = d_burst;
  assign bus0.hport     = d_prot;
  assign bus1.hport     = d_prot;
  assign bus0.htrans    = d_trans;
  assign bus1.htrans    = d_trans;
  assign bus0.hmastlock = d_lock;
  assign bus1.hmastlock = d_lock;
  assign bus0.hwdata    = d_wdata;
  assign bus1.hwdata    = d_wdata;
  assign bus0.hready_in = bus0.hready;
  assign bus1.hready_in = bus1.hready;

  assign obs_rdy = d_dut ? bus1.hready : bus0.hready;
  assign obs_rsp = d_dut ? bus1.hresp  : bus0.hresp;
  assign obs_rd  = d_dut ? bus1.hrdata : bus0.hrdata;

  ahb_sram_slave #(
    .MEM_WORDS   (256),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (2),
    .INIT_FILE   ("")
  ) u_dut_ws2 (
    .hclk  (hclk),
    .hrstn (hrstn),
    .bus   (bus0)
  );

  ahb_sram_slave #(
    .MEM_WORDS   (256),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (0),
    .INIT_FILE   ("")
  ) u_dut_ws0 (
    .hclk  (hclk),
    .hrstn (hrstn),
    .bus   (bus1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // 256 words of 4 bytes starting at address 0.
  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    if (a >= 32'd1024) return 1'b0;
    if (s > 3'd2) return 1'b0;
    return (a % (32'd1 << s)) == 32'd0;
  endfunction

  task automatic model_write(input int d, input xfer_t x);
    int nb;
    int ln;
    nb = 1 << x.size;
    for (int b = 0; b < nb; b++) begin
      ln = int'(x.addr[1:0]) + b;
      mdl[d][x.addr[9:2]][8*ln +: 8] = x.wdata[8*ln +: 8];
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic [2:0] s, input logic [31:0] wd);
    xfer_t x;
    x.trans = t;
    x.addr  = a;
    x.write = w;
    x.size  = s;
    x.wdata = wd;
    q.push_back(x);
  endtask

  task automatic step();
    xfer_t       h;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_rd;
    bit          do_rd;
    int          d;
    d = int'(d_dut);
    @(negedge hclk);
    h = '0;
    if (q.size() > 0) h = q[0];
    d_sel   = 1'b1;
    d_trans = h.trans;
    d_addr  = h.addr;
    d_write = h.write;
    d_size  = h.size;
    d_burst = 3'($urandom_range(0, 7));
    d_prot  = 4'($urandom_range(0, 15));
    d_lock  = 1'($urandom_range(0, 1));
    d_wdata = (dp_act && dp.write) ? dp.wdata : $urandom();
    #1;
    e_rd  = 32'd0;
    do_rd = 1'b1;
    if (!dp_act) begin
      e_rdy = 1'b1;
      e_rsp = 1'b0;
    end else if (!is_legal(dp.addr, dp.size)) begin
      e_rdy = (dp_k >= 1);
      e_rsp = 1'b1;
    end else if (dp_k < ws[d]) begin
      e_rdy = 1'b0;
      e_rsp = 1'b0;
    end else begin
      e_rdy = 1'b1;
      e_rsp = 1'b0;
      do_rd = !dp.write;
      e_rd  = mdl[d][dp.addr[9:2]];
    end
    check_eq($sformatf("hready dut%0d a=%h k=%0d", d, dp.addr, dp_k), {31'd0, obs_rdy}, {31'd0, e_rdy});
    check_eq($sformatf("hresp dut%0d a=%h k=%0d", d, dp.addr, dp_k), {31'd0, obs_rsp}, {31'd0, e_rsp});
    if (do_rd) check_eq($sformatf("hrdata dut%0d a=%h k=%0d", d, dp.addr, dp_k), obs_rd, e_rd);
    if (e_rdy) begin
      if (dp_act && dp.write && is_legal(dp.addr, dp.size)) model_write(d, dp);
      dp_act = 1'b0;
      if (q.size() > 0) begin
        h = q.pop_front();
        if (h.trans[1]) begin
          dp     = h;
          dp_act = 1'b1;
          dp_k   = 0;
        end
      end
    end else begin
      dp_k++;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q.size() > 0 || dp_act) && budget < 4000) begin
      step();
      budget++;
    end
    check_eq("drain_complete", q.size() + int'(dp_act), 32'd0);
  endtask

  task automatic rand_xfers(input int n);
    logic [2:0]  s;
    logic [31:0] a;
    logic [1:0]  t;
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 255)) * 4;
      if (s <= 3'd2) a = a + ((32'($urandom_range(0, 3)) >> s) << s);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 11) == 0) a = 32'd1024 + 32'($urandom_range(0, 4095));
      t = 2'($urandom_range(0, 9) < 7 ? $urandom_range(2, 3) : $urandom_range(0, 1));
      push(t, a, 1'($urandom_range(0, 1)), s, $urandom());
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] old40;
    int          guard;
    hrstn = 1'b1;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_eq("rst_hready_ws2", {31'd0, bus0.hready}, 32'd1);
    check_eq("rst_hresp_ws2", {31'd0, bus0.hresp}, 32'd0);
    check_eq("rst_hrdata_ws2", bus0.hrdata, 32'd0);
    check_eq("rst_hready_ws0", {31'd0, bus1.hready}, 32'd1);
    check_eq("rst_hresp_ws0", {31'd0, bus1.hresp}, 32'd0);
    check_eq("rst_hrdata_ws0", bus1.hrdata, 32'd0);
    hrstn = 1'b0;

    for (int d = 0; d < 2; d++) begin
      d_dut = 1'(d);
      for (int w = 0; w < 256; w++) push(2'b10, 32'(w) * 4, 1'b1, 3'd2, $urandom());
      drain();
    end

    d_dut = 1'b0;
    push(2'b10, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
    push(2'b10, 32'h10, 1'b0, 3'd2, 32'd0);
    drain();

    d_dut = 1'b1;
    for (int w = 0; w < 4; w++) push(2'b10, 32'(w) * 4, 1'b1, 3'd2, 32'(w));
    push(2'b10, 32'h0, 1'b0, 3'd2, 32'd0);
    push(2'b11, 32'h4, 1'b0, 3'd2, 32'd0);
    push(2'b01, 32'h8, 1'b0, 3'd2, 32'd0);
    push(2'b11, 32'h8, 1'b0, 3'd2, 32'd0);
    push(2'b11, 32'hC, 1'b0, 3'd2, 32'd0);
    push(2'b10, 32'h20, 1'b1, 3'd2, 32'h1122_3344);
    push(2'b10, 32'h21, 1'b1, 3'd0, 32'h0000_AA00);
    push(2'b10, 32'h22, 1'b1, 3'd1, 32'h5566_0000);
    push(2'b10, 32'h20, 1'b0, 3'd2, 32'd0);
    push(2'b10, 32'h80, 1'b1, 3'd2, 32'h0BAD_CAFE);
    push(2'b10, 32'h80, 1'b0, 3'd2, 32'd0);
    drain();
    check_eq("byte_half_merge_model", mdl[1][8], 32'h5566_AA44);

    d_dut = 1'b0;
    push(2'b10, 32'h400, 1'b0, 3'd2, 32'd0);
    push(2'b10, 32'h3, 1'b0, 3'd1, 32'd0);
    push(2'b10, 32'h10, 1'b0, 3'd2, 32'd0);
    push(2'b10, 32'h22, 1'b1, 3'd2, 32'hFFFF_FFFF);
    push(2'b10, 32'h20, 1'b1, 3'd3, 32'hFFFF_FFFF);
    push(2'b10, 32'h20, 1'b0, 3'd2, 32'd0);
    drain();

    old40 = mdl[0][16];
    push(2'b10, 32'h40, 1'b1, 3'd2, ~old40);
    guard = 0;
    while (!dp_act && guard < 20) begin
      step();
      guard++;
    end
    check_eq("rst_wait_entered", {31'd0, dp_act}, 32'd1);
    @(negedge hclk);
    d_trans = 2'b00;
    check_eq("pre_rst_in_wait", {31'd0, obs_rdy}, 32'd0);
    #1 hrstn = 1'b1;
    #1;
    check_eq("midrst_hready", {31'd0, obs_rdy}, 32'd1);
    check_eq("midrst_hresp", {31'd0, obs_rsp}, 32'd0);
    check_eq("midrst_hrdata", obs_rd, 32'd0);
    #1 hrstn = 1'b0;
    dp_act = 1'b0;
    push(2'b10, 32'h40, 1'b0, 3'd2, 32'd0);
    drain();

    for (int d = 0; d < 2; d++) begin
      d_dut = 1'(d);
      rand_xfers(250);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
